noobs_mem_ctrl: RTL and testbench

NOOBS_MEM_CTRL -- requirements
Module: noobs_mem_ctrl

---
 rtl/noobs_mem_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_noobs_mem_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noobs_mem_ctrl.sv
// -----------------------------------------------------------------------------
// noobs_mem_ctrl
//
// Purpose:
//   Shares one single-port synchronous memory between an instruction-fetch
//   requester (read only) and a data requester (read/write). A four-state FSM
//   (IDLE -> ACCESS -> WAIT -> DONE) serves one request at a time:
//     - IDLE   : arbitrate, latch the winner's address/write/wdata.
//     - ACCESS : first memory cycle (mem_en high).
//     - WAIT   : WAIT_CYCLES further memory cycles (skipped when 0).
//     - DONE   : one-cycle ack to the winner, memory bus idle.
//   A saturating 8-bit counter records IDLE cycles in which both ports
//   requested at once.
//
// Parameters:
//   DATA_W      - data width.
//   ADDR_W      - address width.
//   WAIT_CYCLES - extra memory wait states, 0..15.
//   ARB_MODE    - 0: data port always wins a tie; 1: round-robin on ties.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset.
//   i_req/i_addr               - fetch request (held until i_ack) and address.
//   i_ack/i_rdata              - fetch completion pulse and fetched data.
//   d_req/d_wr/d_addr/d_wdata  - data request (held until d_ack), direction,
//                                address and write data.
//   d_ack/d_rdata              - data completion pulse and read data.
//   mem_en/mem_wr/mem_addr/
//   mem_wdata/mem_rdata        - shared memory port.
//   busy                       - FSM is outside IDLE.
//   stat_clr/conflict_cnt      - clear and value of the conflict counter.
// -----------------------------------------------------------------------------
module noobs_mem_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1,
    parameter int ARB_MODE    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    input  logic              stat_clr,
    output logic [7:0]        conflict_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // WAIT is entered with WAIT_CYCLES-1 and left when the counter reads 0,
    // so it lasts exactly WAIT_CYCLES cycles. Unused when WAIT_CYCLES is 0.
    localparam logic [3:0] LP_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            r_state;
    logic              r_grant_d;     // current transaction belongs to data port
    logic              r_last_d;      // last grant pointer, 1 = data
    logic [3:0]        r_wait_cnt;
    logic              r_mem_en;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_i_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [7:0]        r_conflict_cnt;

    logic              w_conflict;
    logic              w_grant_d;
    logic              w_last_beat;

    assign w_conflict = i_req && d_req;

    // NOTE: every signal written in an always_comb gets a default at the top,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_grant_d   = d_req;
        w_last_beat = 1'b0;
        if (w_conflict) begin
            // Fixed mode favours data; round-robin favours whoever was not
            // served last.
            w_grant_d = (ARB_MODE == 0) ? 1'b1 : !r_last_d;
        end
        if ((r_state == S_ACCESS && WAIT_CYCLES == 0) ||
            (r_state == S_WAIT && r_wait_cnt == 4'd0)) begin
            w_last_beat = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant_d   <= 1'b0;
            r_last_d    <= 1'b0;
            r_wait_cnt  <= 4'd0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        // The memory bus registers double as the request latch:
                        // inputs may change freely once this edge has passed.
                        r_state   <= S_ACCESS;
                        r_mem_en  <= 1'b1;
                        r_grant_d <= w_grant_d;
                        r_last_d  <= w_grant_d;
                        if (w_grant_d) begin
                            r_mem_wr    <= d_wr;
                            r_mem_addr  <= d_addr;
                            r_mem_wdata <= d_wdata;
                        end else begin
                            r_mem_wr    <= 1'b0;
                            r_mem_addr  <= i_addr;
                            r_mem_wdata <= '0;
                        end
                    end
                end

                S_ACCESS, S_WAIT: begin
                    if (w_last_beat) begin
                        // Leaving the last mem_en cycle: capture read data,
                        // park the bus at zero and raise the winner's ack.
                        r_state     <= S_DONE;
                        r_mem_en    <= 1'b0;
                        r_mem_wr    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        if (!r_mem_wr) begin
                            if (r_grant_d) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                        if (r_grant_d) begin
                            r_d_ack <= 1'b1;
                        end else begin
                            r_i_ack <= 1'b1;
                        end
                    end else if (r_state == S_ACCESS) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= LP_WAIT_LOAD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end

                S_DONE: begin
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Conflict statistics: clear has priority over counting, and the count
    // sticks at 255 rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            r_conflict_cnt <= 8'd0;
        end else if (r_state == S_IDLE && w_conflict && r_conflict_cnt != 8'hFF) begin
            r_conflict_cnt <= r_conflict_cnt + 8'd1;
        end
    end

    assign i_ack        = r_i_ack;
    assign i_rdata      = r_i_rdata;
    assign d_ack        = r_d_ack;
    assign d_rdata      = r_d_rdata;
    assign mem_en       = r_mem_en;
    assign mem_wr       = r_mem_wr;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign busy         = (r_state != S_IDLE);
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_noobs_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_noobs_mem_ctrl
//
// Purpose:
//   Self-checking bench for noobs_mem_ctrl. Two instances run side by side:
//     inst 0 : WAIT_CYCLES=1, ARB_MODE=0 (fixed data priority)
//     inst 1 : WAIT_CYCLES=0, ARB_MODE=1 (round-robin)
//   Requests push their expected outcome onto a scoreboard; a monitor pops
//   the matching entry on every ack and compares the observed memory burst
//   and returned data. The memory model only presents valid read data in the
//   last cycle of a burst, so early or late capture is visible.
// -----------------------------------------------------------------------------
module tb_noobs_mem_ctrl;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int NI = 2;

    typedef struct {
        int          inst;
        bit          port;    // 1 = data, 0 = fetch
        bit          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } sb_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req     [NI];
    logic [AW-1:0] i_addr    [NI];
    logic          i_ack     [NI];
    logic [DW-1:0] i_rdata   [NI];
    logic          d_req     [NI];
    logic          d_wr      [NI];
    logic [AW-1:0] d_addr    [NI];
    logic [DW-1:0] d_wdata   [NI];
    logic          d_ack     [NI];
    logic [DW-1:0] d_rdata   [NI];
    logic          mem_en    [NI];
    logic          mem_wr    [NI];
    logic [AW-1:0] mem_addr  [NI];
    logic [DW-1:0] mem_wdata [NI];
    logic [DW-1:0] mem_rdata [NI];
    logic          busy      [NI];
    logic          stat_clr  [NI];
    logic [7:0]    conflict_cnt [NI];

    int            cycle = 0;
    int            n_vec = 0;
    int            n_bad = 0;
    sb_t           sb[$];
    logic [DW-1:0] mdl_d [NI];     // expected d_rdata per instance
    logic [31:0]   glog  [NI];     // grant history, 1 = data, newest in bit 0
    bit            raw   [NI];     // acks of unscored stimulus are not popped

    // Burst monitor state
    bit            b_on    [NI];
    bit            b_bad   [NI];
    int            b_start [NI];
    int            b_len   [NI];
    logic [AW-1:0] b_addr  [NI];
    logic [DW-1:0] b_wdata [NI];
    logic          b_wr    [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic int wait_of(input int g);
        return (g == 0) ? 1 : 0;
    endfunction

    function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
        if (a == 12'h010) return 8'hA5;
        return a[7:0] ^ 8'h69;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        int en_len = 0;

        noobs_mem_ctrl #(
            .DATA_W      (DW),
            .ADDR_W      (AW),
            .WAIT_CYCLES ((g == 0) ? 1 : 0),
            .ARB_MODE    (g)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .i_req        (i_req[g]),
            .i_addr       (i_addr[g]),
            .i_ack        (i_ack[g]),
            .i_rdata      (i_rdata[g]),
            .d_req        (d_req[g]),
            .d_wr         (d_wr[g]),
            .d_addr       (d_addr[g]),
            .d_wdata      (d_wdata[g]),
            .d_ack        (d_ack[g]),
            .d_rdata      (d_rdata[g]),
            .mem_en       (mem_en[g]),
            .mem_wr       (mem_wr[g]),
            .mem_addr     (mem_addr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_rdata    (mem_rdata[g]),
            .busy         (busy[g]),
            .stat_clr     (stat_clr[g]),
            .conflict_cnt (conflict_cnt[g])
        );

        // Memory: read data is valid only in the final cycle of the burst.
        always @(posedge clk) en_len <= mem_en[g] ? en_len + 1 : 0;
        assign mem_rdata[g] = (mem_en[g] && en_len == ((g == 0) ? 1 : 0)) ?
                              rd_pattern(mem_addr[g]) : 8'hEE;

        always @(negedge clk) monitor(g);
    end

    task automatic score_ack(input int g);
        bit  port;
        int  idx;
        sb_t e;
        port = d_ack[g];
        idx  = -1;
        check("ack_exclusive", 32'(i_ack[g] & d_ack[g]), 32'd0);
        if (raw[g]) return;
        foreach (sb[k]) begin
            if (idx < 0 && sb[k].inst == g && sb[k].port == port) idx = k;
        end
        if (idx < 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
            return;
        end
        e = sb[idx];
        sb.delete(idx);
        glog[g] = {glog[g][30:0], port};
        check("burst_addr",   32'(b_addr[g]), 32'(e.addr));
        check("burst_wr",     32'(b_wr[g]), 32'(e.wr));
        if (e.wr) check("burst_wdata", 32'(b_wdata[g]), 32'(e.wdata));
        check("burst_len",    32'(b_len[g]), 32'(wait_of(g) + 1));
        check("burst_stable", 32'(b_bad[g]), 32'd0);
        check("ack_after_burst", 32'(cycle - b_start[g]), 32'(wait_of(g) + 1));
        check("rdata", 32'(port ? d_rdata[g] : i_rdata[g]), 32'(e.rdata));
        check("done_bus_zero", {mem_en[g], mem_wr[g], 6'd0, mem_addr[g], mem_wdata[g]}, 32'd0);
        check("done_busy", 32'(busy[g]), 32'd1);
    endtask

    task automatic monitor(input int g);
        if (mem_en[g]) begin
            if (!b_on[g]) begin
                b_start[g] = cycle;
                b_len[g]   = 1;
                b_bad[g]   = 1'b0;
                b_addr[g]  = mem_addr[g];
                b_wdata[g] = mem_wdata[g];
                b_wr[g]    = mem_wr[g];
            end else begin
                b_len[g]++;
                if ({mem_addr[g], mem_wdata[g], mem_wr[g]} !== {b_addr[g], b_wdata[g], b_wr[g]})
                    b_bad[g] = 1'b1;
            end
            b_on[g] = 1'b1;
        end else begin
            b_on[g] = 1'b0;
        end
        if (i_ack[g] || d_ack[g]) score_ack(g);
    endtask

    // Issue one request, wait (bounded) for its ack, then keep req low for
    // the following IDLE cycle before returning.
    task automatic do_req(input int g, input bit port, input bit wr,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input bit chk_lat);
        sb_t e;
        int  t0;
        bit  got;
        e.inst  = g;
        e.port  = port;
        e.wr    = port & wr;
        e.addr  = addr;
        e.wdata = wdata;
        if (port && !wr) mdl_d[g] = rd_pattern(addr);
        e.rdata = port ? mdl_d[g] : rd_pattern(addr);
        sb.push_back(e);
        if (port) begin
            d_req[g] = 1'b1; d_wr[g] = wr; d_addr[g] = addr; d_wdata[g] = wdata;
        end else begin
            i_req[g] = 1'b1; i_addr[g] = addr;
        end
        t0  = cycle;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (chk_lat && k == 0) begin
                // Already granted: these changes must not reach the memory.
                if (port) begin
                    d_wr[g] = ~wr; d_addr[g] = ~addr; d_wdata[g] = ~wdata;
                end else begin
                    i_addr[g] = ~addr;
                end
            end
            got = port ? d_ack[g] : i_ack[g];
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        else if (chk_lat) check("ack_latency", 32'(cycle - t0), 32'(wait_of(g) + 2));
        if (port) begin
            d_req[g] = 1'b0; d_addr[g] = AW'($urandom); d_wdata[g] = DW'($urandom);
        end else begin
            i_req[g] = 1'b0; i_addr[g] = AW'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle_conflict(input int g);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = !busy[g] && i_req[g] && d_req[g];
        end
        if (!found) check("idle_conflict_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int g = 0; g < NI; g++) begin
            i_req[g] = 1'b1; i_addr[g] = '0; d_req[g] = 1'b1; d_wr[g] = 1'b0;
            d_addr[g] = '0; d_wdata[g] = '0; stat_clr[g] = 1'b0;
            mdl_d[g] = '0; glog[g] = '0; raw[g] = 1'b0; b_on[g] = 1'b0;
            b_bad[g] = 1'b0; b_start[g] = 0; b_len[g] = 0;
            b_addr[g] = '0; b_wdata[g] = '0; b_wr[g] = 1'b0;
        end

        // Reset with requests high: they must be ignored.
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            i_req[g] = 1'b0; d_req[g] = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check("rst_busy",     32'(busy[g]), 32'd0);
            check("rst_mem",      {mem_en[g], mem_wr[g], 6'd0, mem_addr[g], mem_wdata[g]}, 32'd0);
            check("rst_acks",     32'({i_ack[g], d_ack[g]}), 32'd0);
            check("rst_rdata",    32'({i_rdata[g], d_rdata[g]}), 32'd0);
            check("rst_conflict", 32'(conflict_cnt[g]), 32'd0);
        end

        // Single transactions with latency and input-latching checks.
        do_req(0, 1'b0, 1'b0, 12'h010, 8'h00, 1'b1);   // fetch 0x010 -> 0xA5
        do_req(0, 1'b1, 1'b0, 12'h123, 8'h00, 1'b1);   // data read
        do_req(0, 1'b1, 1'b1, 12'h456, 8'h99, 1'b1);   // data write, d_rdata holds
        do_req(1, 1'b1, 1'b0, 12'h123, 8'h00, 1'b1);
        do_req(1, 1'b1, 1'b1, 12'hFFF, 8'h3C, 1'b1);   // zero-wait write
        do_req(1, 1'b0, 1'b0, 12'h010, 8'h00, 1'b1);   // leaves pointer on fetch

        // Round-robin: both ports keep re-requesting, every grant is a tie.
        glog[1] = '0;
        fork
            begin
                do_req(1, 1'b1, 1'b0, 12'h201, 8'h00, 1'b0);
                do_req(1, 1'b1, 1'b0, 12'h202, 8'h00, 1'b0);
            end
            begin
                do_req(1, 1'b0, 1'b0, 12'h301, 8'h00, 1'b0);
                do_req(1, 1'b0, 1'b0, 12'h302, 8'h00, 1'b0);
            end
        join
        check("rr_order_DIDI", glog[1][3:0], 32'b1010);

        // Fixed priority: data first, fetch stays pending and goes next.
        glog[0] = '0;
        fork
            do_req(0, 1'b1, 1'b0, 12'h345, 8'h00, 1'b0);
            do_req(0, 1'b0, 1'b0, 12'h200, 8'h00, 1'b0);
        join
        check("fixed_order_DI", glog[0][1:0], 32'b10);
        check("conflict_one",   32'(conflict_cnt[0]), 32'd1);

        // Saturation: both requests held through 300 IDLE conflict cycles.
        raw[0] = 1'b1;
        d_wr[0] = 1'b0; d_addr[0] = 12'h0AA; i_addr[0] = 12'h0BB;
        i_req[0] = 1'b1; d_req[0] = 1'b1;
        n = 1;   // counter currently reads 1 from the previous tie
        for (int k = 0; k < 4000 && n < 301; k++) begin
            if (!busy[0] && i_req[0] && d_req[0]) n++;
            if (n < 301) @(negedge clk);
        end
        check("conflict_cycles", 32'(n), 32'd301);
        @(negedge clk);
        check("conflict_saturate", 32'(conflict_cnt[0]), 32'd255);
        wait_idle_conflict(0);
        stat_clr[0] = 1'b1;
        @(negedge clk);
        stat_clr[0] = 1'b0;
        check("clear_at_sat", 32'(conflict_cnt[0]), 32'd0);
        wait_idle_conflict(0);
        @(negedge clk);
        check("count_after_clear", 32'(conflict_cnt[0]), 32'd1);
        wait_idle_conflict(0);
        stat_clr[0] = 1'b1;
        @(negedge clk);
        stat_clr[0] = 1'b0;
        check("clear_beats_incr", 32'(conflict_cnt[0]), 32'd0);
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        for (int k = 0; k < 20 && busy[0]; k++) @(negedge clk);
        check("raw_drain", 32'(busy[0]), 32'd0);
        @(negedge clk);
        mdl_d[0] = rd_pattern(12'h0AA);
        raw[0] = 1'b0;

        // Reset during WAIT aborts without ack.
        i_req[0] = 1'b1; i_addr[0] = 12'h055;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_wait_en", 32'({busy[0], mem_en[0]}), 32'b11);
        reset = 1'b1; i_req[0] = 1'b0;
        @(negedge clk);
        check("abort_mem_en", 32'(mem_en[0]), 32'd0);
        check("abort_ack",    32'({i_ack[0], d_ack[0]}), 32'd0);
        check("abort_busy",   32'(busy[0]), 32'd0);
        reset = 1'b0;
        for (int g = 0; g < NI; g++) mdl_d[g] = '0;
        repeat (3) @(negedge clk);
        do_req(0, 1'b0, 1'b0, 12'h3C3, 8'h00, 1'b1);
        do_req(0, 1'b1, 1'b1, 12'h3C4, 8'h77, 1'b1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule
